// File: rtl/urand_gen_if.sv
// ============================================================================
// urand_gen_if : request/seed/sample bundle for the urand_gen generator.
// Revision 1.0 | optional sample_cnt present under URAND_GEN_CNT_EN
// ============================================================================
`default_nettype none

interface urand_gen_if;
  logic        enable;
  logic        seed_load;
  logic [63:0] seed1;
  logic [63:0] seed2;
  logic        pushout;
  logic [63:0] U1;
  logic [63:0] U2;
`ifdef URAND_GEN_CNT_EN
  logic [31:0] sample_cnt;
`endif

  modport master (
    output enable, seed_load, seed1, seed2,
    input  pushout, U1, U2
`ifdef URAND_GEN_CNT_EN
    , input sample_cnt
`endif
  );

  modport slave (
    input  enable, seed_load, seed1, seed2,
    output pushout, U1, U2
`ifdef URAND_GEN_CNT_EN
    , output sample_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/urand_gen.sv
// ============================================================================
// urand_gen : two xorshift64 generators feeding a 2-stage int-to-double path.
// Revision 1.0 | macro URAND_GEN_CNT_EN adds the 32-bit sample_cnt output
// ============================================================================
`default_nettype none

module urand_gen #(
  parameter logic [63:0] DEFAULT_SEED1 = 64'h9E3779B97F4A7C15,
  parameter logic [63:0] DEFAULT_SEED2 = 64'hD1B54A32D192ED03
) (
  input  logic        clk,
  input  logic        rst,
  urand_gen_if.slave  bus
);

  function automatic logic [63:0] xs64(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // The leading one becomes the implicit bit; everything below it is the fraction.
  function automatic logic [63:0] to_double(input logic [63:0] r);
    logic [6:0]  lz;
    logic [63:0] frac;
    lz = 7'd0;
    for (int i = 0; i < 64; i++) begin
      if (r[i]) lz = 7'(63 - i);
    end
    frac = r << (lz + 7'd1);
    return {1'b0, 11'd1022 - {4'd0, lz}, frac[63:12]};
  endfunction

  logic [63:0] r_x1, r_x2;
  logic [63:0] r_r1, r_r2;
  logic        r_v1;
  logic        r_pushout;
  logic [63:0] r_u1, r_u2;
`ifdef URAND_GEN_CNT_EN
  logic [31:0] r_cnt;
`endif

  logic [63:0] w_nx1, w_nx2;
  logic [63:0] w_u1, w_u2;
  logic        w_emit;

  assign w_nx1  = xs64(r_x1);
  assign w_nx2  = xs64(r_x2);
  assign w_u1   = to_double(r_r1);
  assign w_u2   = to_double(r_r2);
  assign w_emit = r_v1 && (r_r1 != 64'd0) && (r_r2 != 64'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x1      <= DEFAULT_SEED1;
      r_x2      <= DEFAULT_SEED2;
      r_r1      <= 64'd0;
      r_r2      <= 64'd0;
      r_v1      <= 1'b0;
      r_pushout <= 1'b0;
      r_u1      <= 64'd0;
      r_u2      <= 64'd0;
`ifdef URAND_GEN_CNT_EN
      r_cnt     <= 32'd0;
`endif
    end else if (bus.seed_load) begin
      // A zero seed would lock xorshift at zero forever, so substitute the default.
      r_x1      <= (bus.seed1 == 64'd0) ? DEFAULT_SEED1 : bus.seed1;
      r_x2      <= (bus.seed2 == 64'd0) ? DEFAULT_SEED2 : bus.seed2;
      r_v1      <= 1'b0;
      r_pushout <= 1'b0;
`ifdef URAND_GEN_CNT_EN
      r_cnt     <= 32'd0;
`endif
    end else begin
      if (bus.enable) begin
        r_x1 <= w_nx1;
        r_x2 <= w_nx2;
        r_r1 <= w_nx1;
        r_r2 <= w_nx2;
        r_v1 <= 1'b1;
      end else begin
        r_v1 <= 1'b0;
      end

      if (w_emit) begin
        r_u1      <= w_u1;
        r_u2      <= w_u2;
        r_pushout <= 1'b1;
`ifdef URAND_GEN_CNT_EN
        r_cnt     <= r_cnt + 32'd1;
`endif
      end else begin
        r_pushout <= 1'b0;
      end
    end
  end

  assign bus.pushout = r_pushout;
  assign bus.U1      = r_u1;
  assign bus.U2      = r_u2;
`ifdef URAND_GEN_CNT_EN
  assign bus.sample_cnt = r_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_urand_gen.sv
// ============================================================================
// tb_urand_gen : directed-vector bench for urand_gen.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_urand_gen;
  localparam logic [63:0] D1 = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] D2 = 64'hD1B54A32D192ED03;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  urand_gen_if bus ();

  urand_gen #(
    .DEFAULT_SEED1(D1),
    .DEFAULT_SEED2(D2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] m1, m2;

  typedef struct {
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] u1;
    logic [63:0] u2;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [63:0] ref_xs(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  // Normalise by shifting until bit 63 is set; value = r / 2^64.
  function automatic logic [63:0] ref_conv(input logic [63:0] r);
    logic [63:0] m;
    int e;
    if (r == 64'd0) return 64'd0;
    m = r;
    e = 1022;
    while (!m[63]) begin
      m = m << 1;
      e = e - 1;
    end
    return {1'b0, 11'(e), m[62:11]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b);
    bus.seed_load = 1'b1;
    bus.seed1     = a;
    bus.seed2     = b;
    step();
    bus.seed_load = 1'b0;
    m1 = (a == 64'd0) ? D1 : a;
    m2 = (b == 64'd0) ? D2 : b;
  endtask

  // Enable for n cycles from the current model state; expects pushout on edges 1..n.
  task automatic stream(input int n, input string nm);
    int seen;
    seen = 0;
    for (int c = 0; c <= n + 1; c++) begin
      bus.enable = (c < n);
      step();
      if (c >= 1 && c <= n) begin
        m1 = ref_xs(m1);
        m2 = ref_xs(m2);
        chk({nm, "_pushout"}, {63'd0, bus.pushout}, 64'd1);
        chk({nm, "_U1"}, bus.U1, ref_conv(m1));
        chk({nm, "_U2"}, bus.U2, ref_conv(m2));
        chk({nm, "_fmt"}, {63'd0, (bus.U1[63] | bus.U2[63] |
                                   (bus.U1[62:52] > 11'd1022) |
                                   (bus.U2[62:52] > 11'd1022))}, 64'd0);
        if (bus.pushout) seen++;
      end else begin
        chk({nm, "_idle"}, {63'd0, bus.pushout}, 64'd0);
      end
    end
    bus.enable = 1'b0;
    chk({nm, "_count"}, 64'(seen), 64'(n));
  endtask

  initial begin
    rst           = 1'b0;
    bus.enable    = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed1     = 64'd0;
    bus.seed2     = 64'd0;
    step();
    step();
    chk("reset_pushout", {63'd0, bus.pushout}, 64'd0);
    chk("reset_U1", bus.U1, 64'd0);
    chk("reset_U2", bus.U2, 64'd0);
    rst = 1'b1;

    vecs[0] = '{64'd1, 64'd2, 64'h3DD0208810400000, 64'h3DE0208810400000};
    vecs[1] = '{64'h80, 64'hFFFFFFFFFFFFFFFF, 64'h3E40208910408000, 64'h3DCFC00FE0000000};
    vecs[2] = '{64'd2, 64'h80, 64'h3DE0208810400000, 64'h3E40208910408000};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'd1, 64'h3DCFC00FE0000000, 64'h3DD0208810400000};

    for (int i = 0; i < 4; i++) begin
      load(vecs[i].s1, vecs[i].s2);
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      chk("vec_latency", {63'd0, bus.pushout}, 64'd0);
      step();
      chk("vec_pushout", {63'd0, bus.pushout}, 64'd1);
      chk("vec_U1", bus.U1, vecs[i].u1);
      chk("vec_U2", bus.U2, vecs[i].u2);
      step();
      chk("vec_drop", {63'd0, bus.pushout}, 64'd0);
      chk("vec_hold_U1", bus.U1, vecs[i].u1);
      chk("vec_hold_U2", bus.U2, vecs[i].u2);
    end

    load(64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
    stream(100, "stream100");

    // seed_load with enable while two pairs are in flight
    load(64'd5, 64'd7);
    bus.enable = 1'b1;
    step();
    step();
    bus.seed_load = 1'b1;
    bus.seed1     = 64'd1;
    bus.seed2     = 64'd2;
    step();
    bus.seed_load = 1'b0;
    bus.enable    = 1'b0;
    chk("flush_edge0", {63'd0, bus.pushout}, 64'd0);
    step();
    chk("flush_edge1", {63'd0, bus.pushout}, 64'd0);
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    chk("flush_edge2", {63'd0, bus.pushout}, 64'd0);
    step();
    chk("flush_pushout", {63'd0, bus.pushout}, 64'd1);
    chk("flush_U1", bus.U1, vecs[0].u1);
    chk("flush_U2", bus.U2, vecs[0].u2);

    load(64'd0, 64'd0);
    stream(3, "zeroseed");
    load(64'd0, 64'd2);
    stream(2, "halfzero");

    // reset pulse in the middle of a burst
    load(64'd1, 64'd2);
    bus.enable = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;
    step();
    chk("midrst_pushout", {63'd0, bus.pushout}, 64'd0);
    chk("midrst_U1", bus.U1, 64'd0);
    chk("midrst_U2", bus.U2, 64'd0);
    rst = 1'b1;
    m1  = D1;
    m2  = D2;
    stream(4, "postrst");

`ifdef URAND_GEN_CNT_EN
    load(64'd1, 64'd1);
    chk("cnt_clear", 64'(bus.sample_cnt), 64'd0);
    stream(5, "cnt");
    chk("cnt_five", 64'(bus.sample_cnt), 64'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/urand_gen.md
URAND_GEN -- requirements
Module: urand_gen

Interface
REQ-001 Parameter DEFAULT_SEED1, 64'h9E3779B97F4A7C15, generator-1 state after reset or after a zero seed load.
REQ-002 Parameter DEFAULT_SEED2, 64'hD1B54A32D192ED03, generator-2 state after reset or after a zero seed load.
REQ-003 Ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-004 Ports: rst  in  1  synchronous, active-low reset.
REQ-005 Ports: enable  in  1  request one (U1,U2) sample pair this cycle.
REQ-006 Ports: seed_load  in  1  load seed1/seed2 into generator state this cycle.
REQ-007 Ports: seed1, seed2  in  64 each  seed values.
REQ-008 Ports: pushout  out  1  U1/U2 valid for exactly this cycle; drives the downstream pushin directly.
REQ-009 Ports: U1, U2  out  64 each  IEEE-754 doubles, uniform in (0,1).

Function
REQ-010 Each generator SHALL be xorshift64, updated on an accepted enable: x^=x<<13; x^=x>>7; x^=x<<17; stage-1 register r SHALL take the new x.
REQ-011 Pipeline SHALL be 2 stages: enable sampled at edge n -> U1/U2/pushout registered at edge n+1, i.e. pushout high in the cycle after the one following enable; full throughput of 1 pair per cycle.
REQ-012 Conversion per output: lz = leading-zero count of r (0..63); exponent = 1022-lz; sign = 0; mantissa = bits of r below the leading one, left-justified into 52 bits, truncated or zero-padded.
REQ-013 Zero sample: if r1==0 or r2==0, that pair SHALL be discarded (no pushout, U1/U2 hold); generator state SHALL still advance.
REQ-014 U1/U2 SHALL hold their last value while pushout is low.
REQ-015 seed_load SHALL take priority over a simultaneous enable: state loads, the enable is ignored, stage-1 and stage-2 valids clear (in-flight pairs dropped).
REQ-016 A seed of 0 SHALL load the corresponding DEFAULT_SEED instead (the xorshift lock-up state is never entered).
REQ-017 Generators SHALL be independent; seed_load affects both simultaneously.
REQ-018 No backpressure: the consumer accepts every pushout.

Reset
REQ-019 While rst==0 at an edge: states <= DEFAULT_SEED1/2; stage valids <= 0; pushout <= 0; U1, U2 <= 0; sample_cnt <= 0 (if present).
REQ-020 Reset mid-operation SHALL drop all in-flight pairs; the first enable after release yields the same pair as after power-up.

Configuration
REQ-021 Macro URAND_GEN_CNT_EN: when defined, add output sample_cnt (32 bits, out), counting emitted pushouts, wrapping 0xFFFFFFFF -> 0, cleared by reset and by seed_load; when undefined, the port and counter are absent and other behaviour is identical.

Verification
REQ-022 seed_load with seed1=1 -> enable 1 cycle -> 2 cycles later pushout=1 and U1=64'h3DD0208810400000.
REQ-023 enable held high for 100 cycles after seed load -> exactly 100 consecutive pushouts, 2-cycle latency, all U1/U2 with sign 0 and exponent <=1022.
REQ-024 seed_load and enable asserted together with a pair in flight -> no pushout for the dropped pairs; the next enable output matches the fresh-seed sequence.
REQ-025 seed1=seed2=0 loaded -> outputs identical to the post-reset sequence.
REQ-026 rst low for 1 cycle during a streaming burst -> pushout=0, U1=U2=0 the next cycle; the sequence restarts from the defaults.
REQ-027 With URAND_GEN_CNT_EN: 5 pushouts -> sample_cnt=5; preload so the count sits at 0xFFFFFFFF, then 1 more pushout -> sample_cnt=0.
